// File: rtl/mem_wait_ram_if.sv
// Bus between the MAR/MDR memory-interface stage (master) and the
// wait-state RAM (slave): level strobes, address and write data go
// downstream; read data, completion handshake and status come back.
interface mem_wait_ram_if;
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        finished;
    logic        busy;
    logic        fault;

    modport master (
        output read,
        output write,
        output address,
        output data_in,
        input  data_out,
        input  finished,
        input  busy,
        input  fault
    );

    modport slave (
        input  read,
        input  write,
        input  address,
        input  data_in,
        output data_out,
        output finished,
        output busy,
        output fault
    );
endinterface

// File: rtl/mem_wait_ram.sv
// Word-addressed 32-bit RAM with a fixed access latency.
// A request is accepted only in IDLE; the address, data and operation are
// latched at acceptance, the access happens LATENCY edges later, and
// finished then stays high until the originating strobe is released.
// Optional feature macro: RAM_BOUNDS_CHECK_EN (out-of-range accesses are
// sequenced normally but writes are suppressed, reads return zero and
// fault is raised in DONE). Without it the address wraps modulo DEPTH.
module mem_wait_ram #(
    parameter int DEPTH   = 512,
    parameter int LATENCY = 3,
    parameter int AW      = 9
) (
    input  logic         clock,
    input  logic         clear,
    mem_wait_ram_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_reg;
    state_t        state_next;

    logic [3:0]    cnt_reg;
    logic          op_wr_reg;
    logic [AW-1:0] addr_reg;
    logic [31:0]   wdata_reg;
    logic          oor_reg;
    logic [31:0]   data_out_reg;
    logic          finished_reg;

    // Zero at time 0; never touched by clear.
    logic [31:0]   mem [DEPTH] = '{default: '0};

    logic          req_rd;
    logic          req_wr;
    logic          req_ok;
    logic          strobe_held;
    logic          accept;
    logic          access_fire;
    logic          mem_we;
    logic          rd_fire;
    logic          oor_now;

    // Upper address bits only matter to the bounds check; otherwise they
    // are deliberately discarded (address wraps).
    logic          unused_addr_hi;
    assign unused_addr_hi = ^bus.address[31:AW];

`ifdef RAM_BOUNDS_CHECK_EN
    assign oor_now = |bus.address[31:AW];
`else
    assign oor_now = 1'b0;
`endif

    // Request decode: exactly one strobe is a legal request.
    always_comb begin
        req_rd      = bus.read & ~bus.write;
        req_wr      = bus.write & ~bus.read;
        req_ok      = req_rd | req_wr;
        strobe_held = op_wr_reg ? bus.write : bus.read;
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req_ok) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt_reg == 4'd0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (!strobe_held) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output and strobe decode from the current state.
    always_comb begin
        accept      = (state_reg == IDLE) && req_ok;
        access_fire = (state_reg == WAIT) && (cnt_reg == 4'd0);
        mem_we      = access_fire && op_wr_reg && !oor_reg;
        rd_fire     = access_fire && !op_wr_reg;
        bus.busy    = (state_reg != IDLE);
`ifdef RAM_BOUNDS_CHECK_EN
        bus.fault   = (state_reg == DONE) && oor_reg;
`else
        bus.fault   = 1'b0;
`endif
    end

    assign bus.data_out = data_out_reg;
    assign bus.finished = finished_reg;

    // State register, latency counter, request latches and read data.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_reg    <= IDLE;
            cnt_reg      <= 4'd0;
            op_wr_reg    <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            oor_reg      <= 1'b0;
            data_out_reg <= '0;
            finished_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            finished_reg <= (state_next == DONE);
            if (accept) begin
                op_wr_reg <= req_wr;
                addr_reg  <= bus.address[AW-1:0];
                wdata_reg <= bus.data_in;
                oor_reg   <= oor_now;
                cnt_reg   <= 4'(LATENCY - 1);
            end else if ((state_reg == WAIT) && (cnt_reg != 4'd0)) begin
                cnt_reg <= cnt_reg - 4'd1;
            end
            if (rd_fire) begin
                data_out_reg <= oor_reg ? 32'd0 : mem[addr_reg];
            end
        end
    end

    // Array write port; a clear on the access edge drops the write.
    always_ff @(posedge clock) begin
        if (mem_we && !clear) begin
            mem[addr_reg] <= wdata_reg;
        end
    end

endmodule

// File: tb/tb_mem_wait_ram.sv
// Self-checking bench for mem_wait_ram: directed table, multi-cycle corner
// sequences, a latency sweep on extra instances and a randomized run
// against a transaction-level memory model.
module tb_mem_wait_ram;

    logic clock = 1'b0;
    logic clear;
    always #5 clock = ~clock;

    mem_wait_ram_if bus ();
    mem_wait_ram_if bus1 ();
    mem_wait_ram_if bus15 ();

    mem_wait_ram #(.DEPTH(512), .LATENCY(3), .AW(9)) u_dut (
        .clock(clock), .clear(clear), .bus(bus.slave));
    mem_wait_ram #(.DEPTH(512), .LATENCY(1), .AW(9)) u_lat1 (
        .clock(clock), .clear(clear), .bus(bus1.slave));
    mem_wait_ram #(.DEPTH(512), .LATENCY(15), .AW(9)) u_lat15 (
        .clock(clock), .clear(clear), .bus(bus15.slave));

    int errors = 0;
    int checks = 0;

    logic [31:0] model [512];
    logic [31:0] last_rd;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_dout;
        bit          exp_fault;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic bit in_range(input logic [31:0] a);
`ifdef RAM_BOUNDS_CHECK_EN
        return (a < 32'd512);
`else
        return 1'b1;
`endif
    endfunction

    // One full transaction on the LATENCY=3 instance. Called #1 after an edge
    // with the DUT idle. When use_exp is set the table values are required,
    // otherwise the model supplies the expectation.
    task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                          input bit early, input bit scramble,
                          input bit use_exp, input logic [31:0] exp_dout,
                          input bit exp_flt, input string tag);
        int          n;
        logic [31:0] exp_d;
        bit          exp_f;
        bus.write   = wr;
        bus.read    = ~wr;
        bus.address = a;
        bus.data_in = d;
        tick();
        check({tag, " busy_after_accept"}, 32'(bus.busy), 32'd1);
        if (scramble) begin
            bus.address = $urandom;
            bus.data_in = $urandom;
        end
        if (early) begin
            bus.read  = 1'b0;
            bus.write = 1'b0;
        end
        n = 0;
        while (!bus.finished && n < 40) begin
            tick();
            n++;
        end
        check({tag, " latency"}, n, 32'd3);

        exp_f = !in_range(a);
        if (wr) begin
            if (in_range(a)) model[a[8:0]] = d;
            exp_d = last_rd;
        end else begin
            exp_d   = in_range(a) ? model[a[8:0]] : 32'd0;
            last_rd = exp_d;
        end
        if (use_exp) begin
            exp_d = exp_dout;
            exp_f = exp_flt;
            if (!wr) last_rd = exp_dout;
        end
        check({tag, " data_out"}, bus.data_out, exp_d);
        check({tag, " fault"}, 32'(bus.fault), 32'(exp_f));
        $display("txn %s wr=%0d addr=%h data=%h early=%0d lat=%0d dout=%h fault=%0b",
                 tag, wr, a, d, early, n, bus.data_out, bus.fault);

        if (!early) begin
            tick();
            check({tag, " finished_held"}, 32'(bus.finished), 32'd1);
            bus.read  = 1'b0;
            bus.write = 1'b0;
        end
        tick();
        check({tag, " finished_release"}, 32'(bus.finished), 32'd0);
        check({tag, " busy_release"}, 32'(bus.busy), 32'd0);
        check({tag, " fault_release"}, 32'(bus.fault), 32'd0);
    endtask

    initial begin
        int n1;
        int n15;

        for (int i = 0; i < 512; i++) model[i] = 32'd0;
        last_rd = 32'd0;

        vecs[0] = '{1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1] = '{1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2] = '{1'b1, 32'h11,  32'h12345678, 32'hDEADBEEF, 1'b0};
        vecs[3] = '{1'b0, 32'h11,  32'h0,        32'h12345678, 1'b0};
        vecs[4] = '{1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
        vecs[5] = '{1'b1, 32'h0,   32'hA5A5A5A5, 32'hDEADBEEF, 1'b0};
`ifdef RAM_BOUNDS_CHECK_EN
        vecs[6] = '{1'b1, 32'h200, 32'h0BADF00D, 32'hDEADBEEF, 1'b1};
        vecs[7] = '{1'b0, 32'h0,   32'h0,        32'hA5A5A5A5, 1'b0};
        vecs[8] = '{1'b0, 32'h200, 32'h0,        32'h0,        1'b1};
`else
        vecs[6] = '{1'b1, 32'h200, 32'h0BADF00D, 32'hDEADBEEF, 1'b0};
        vecs[7] = '{1'b0, 32'h0,   32'h0,        32'h0BADF00D, 1'b0};
        vecs[8] = '{1'b0, 32'h200, 32'h0,        32'h0BADF00D, 1'b0};
`endif

        clear = 1'b1;
        bus.read = 1'b0;   bus.write = 1'b0;   bus.address = 32'd0;   bus.data_in = 32'd0;
        bus1.read = 1'b0;  bus1.write = 1'b0;  bus1.address = 32'd0;  bus1.data_in = 32'd0;
        bus15.read = 1'b0; bus15.write = 1'b0; bus15.address = 32'd0; bus15.data_in = 32'd0;
        tick();
        tick();
        check("reset data_out", bus.data_out, 32'd0);
        check("reset finished", 32'(bus.finished), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset fault", 32'(bus.fault), 32'd0);
        clear = 1'b0;
        tick();

        // Directed table.
        for (int i = 0; i < 9; i++) begin
            access(vecs[i].wr, vecs[i].addr, vecs[i].data, 1'b0, 1'b0,
                   1'b1, vecs[i].exp_dout, vecs[i].exp_fault, $sformatf("vec%0d", i));
        end
        // Keep the model in step with what the table did.
        model[9'h10] = 32'hDEADBEEF;
        model[9'h11] = 32'h12345678;
`ifdef RAM_BOUNDS_CHECK_EN
        model[9'h0]  = 32'hA5A5A5A5;
`else
        model[9'h0]  = 32'h0BADF00D;
`endif

        // Clear two edges into a write: access aborted, write dropped.
        bus.write = 1'b1; bus.address = 32'h20; bus.data_in = 32'h55AA55AA;
        tick();
        tick();
        clear = 1'b1;
        tick();
        check("midreset busy", 32'(bus.busy), 32'd0);
        check("midreset finished", 32'(bus.finished), 32'd0);
        check("midreset data_out", bus.data_out, 32'd0);
        clear = 1'b0;
        bus.write = 1'b0;
        last_rd = 32'd0;
        tick();
        check("postreset busy", 32'(bus.busy), 32'd0);
        access(1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, "rd_after_reset");

        // Both strobes high is ignored.
        bus.read = 1'b1; bus.write = 1'b1; bus.address = 32'h10;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("illegal busy c%0d", i), 32'(bus.busy), 32'd0);
            check($sformatf("illegal finished c%0d", i), 32'(bus.finished), 32'd0);
        end
        bus.read = 1'b0; bus.write = 1'b0;
        tick();

        // Strobe dropped right after acceptance: single-cycle finished.
        access(1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, "early_drop_rd");
        access(1'b1, 32'h12, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, "early_drop_wr");

        // Address/data scrambled during WAIT: latched copies are used.
        access(1'b1, 32'h30, 32'h11112222, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, "scramble_wr");
        access(1'b0, 32'h30, 32'h0, 1'b0, 1'b1, 1'b1, 32'h11112222, 1'b0, "scramble_rd");
        access(1'b0, 32'h31, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, "neighbour_rd");
        access(1'b1, 32'h12, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, "hold_wr");

        // Latency sweep on the LATENCY=1 and LATENCY=15 instances.
        bus1.write = 1'b1;  bus1.address = 32'h5;  bus1.data_in = 32'h01010101;
        bus15.write = 1'b1; bus15.address = 32'h5; bus15.data_in = 32'h15151515;
        tick();
        n1  = -1;
        n15 = -1;
        for (int i = 1; i <= 20; i++) begin
            if (n1 < 0)  check($sformatf("lat1 busy e%0d", i), 32'(bus1.busy), 32'd1);
            if (n15 < 0) check($sformatf("lat15 busy e%0d", i), 32'(bus15.busy), 32'd1);
            tick();
            if (n1 < 0 && bus1.finished)   n1 = i;
            if (n15 < 0 && bus15.finished) n15 = i;
        end
        check("lat1 latency", n1, 32'd1);
        check("lat15 latency", n15, 32'd15);
        check("lat1 finished_held", 32'(bus1.finished), 32'd1);
        bus1.write = 1'b0;
        bus15.write = 1'b0;
        tick();
        check("lat1 release", 32'(bus1.busy), 32'd0);
        check("lat15 release", 32'(bus15.busy), 32'd0);
        bus1.read = 1'b1;  bus1.address = 32'h5;
        bus15.read = 1'b1; bus15.address = 32'h5;
        tick();
        for (int i = 0; i < 16; i++) tick();
        check("lat1 readback", bus1.data_out, 32'h01010101);
        check("lat15 readback", bus15.data_out, 32'h15151515);
        bus1.read = 1'b0;
        bus15.read = 1'b0;
        tick();

        // Randomized traffic against the model.
        for (int i = 0; i < 40; i++) begin
            bit          wr;
            bit          early;
            logic [31:0] a;
            logic [31:0] d;
            wr    = 1'($urandom_range(0, 1));
            early = ($urandom_range(0, 3) == 0);
            a     = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) a = a | 32'h200;
            d     = $urandom;
            access(wr, a, d, early, 1'b1, 1'b0, 32'h0, 1'b0, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
